// File: rtl/common.sv
// Shared core types: instruction classes, RV32 opcode map and fetch-stage constants.
package common;

  typedef enum logic [2:0] {
    OP_TYPE_R,
    OP_TYPE_I,
    OP_TYPE_S,
    OP_TYPE_B,
    OP_TYPE_U,
    OP_TYPE_J,
    OP_TYPE_X
  } instruction_op_type;

  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/optype_decoder.sv
// Maps a 7-bit RV32 opcode to its instruction format class.
module optype_decoder
  import common::*;
(
  input  logic [6:0]         opcode,
  output instruction_op_type optype
);

  always_comb begin
    optype = OP_TYPE_X;
    case (opcode)
      OPC_OP:                                       optype = OP_TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:                     optype = OP_TYPE_I;
      OPC_STORE:                                    optype = OP_TYPE_S;
      OPC_BRANCH:                                   optype = OP_TYPE_B;
      OPC_LUI, OPC_AUIPC:                           optype = OP_TYPE_U;
      OPC_JAL:                                      optype = OP_TYPE_J;
      default:                                      optype = OP_TYPE_X;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, one-entry output buffer, redirect with flush.
//   state  | meaning
//   S_REQ  | issue read at pc_q once the output buffer is empty or draining
//   S_WAIT | read in flight; kill drops the response of a redirected fetch
//   S_HALT | misaligned redirect seen; idle until reset
module instruction_fetch
  import common::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [XLEN-1:0]    imem_resp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  input  logic               dec_ready,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_instr,
  output logic [6:0]         if_opcode,
  output logic [2:0]         if_funct3,
  output instruction_op_type if_optype,
  output logic               fetch_misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            misaligned_q, misaligned_d;
  logic            req_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign req_fire = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    misaligned_d = misaligned_q;

    if (if_valid_q && dec_ready) if_valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_resp_data;
            pc_d       = pc_q + PC_STEP;
          end
        end
      end
      S_HALT: begin
        if_valid_d = 1'b0;
      end
      default: state_d = S_HALT;
    endcase

    // Redirect overrides everything decided above; the buffer is never loaded on a redirect.
    if (redirect_valid && state_q != S_HALT) begin
      pc_d       = redirect_target;
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if ((state_q == S_WAIT && !imem_resp_valid) || req_fire) kill_d = 1'b1;
      if (redirect_target[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
        kill_d       = 1'b0;
        state_d      = S_HALT;
      end
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && state_q == S_REQ) imem_req_valid = !if_valid_q || dec_ready;
  end

  assign imem_req_addr    = pc_q;
  assign if_valid         = if_valid_q;
  assign if_pc            = if_pc_q;
  assign if_instr         = if_instr_q;
  assign if_opcode        = if_instr_q[6:0];
  assign if_funct3        = if_instr_q[14:12];
  assign fetch_misaligned = misaligned_q;

  optype_decoder u_optype_decoder (
    .opcode (if_opcode),
    .optype (if_optype)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus hand-written redirect/halt/wrap sequences.
module tb_instruction_fetch;
  import common::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [31:0]        imem_req_addr;
  logic               imem_resp_valid;
  logic [31:0]        imem_resp_data;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               dec_ready;
  logic               if_valid;
  logic [31:0]        if_pc;
  logic [31:0]        if_instr;
  logic [6:0]         if_opcode;
  logic [2:0]         if_funct3;
  instruction_op_type if_optype;
  logic               fetch_misaligned;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_delay = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .dec_ready        (dec_ready),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .if_opcode        (if_opcode),
    .if_funct3        (if_funct3),
    .if_optype        (if_optype),
    .fetch_misaligned (fetch_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0050_0093;  // addi  (I)
      32'h0000_0004: return 32'h0020_8133;  // add   (R)
      32'h0000_0040: return 32'h0011_2223;  // sw    (S)
      32'h0000_00C0: return 32'h0000_0463;  // beq   (B)
      32'h0000_0100: return 32'h0000_10B7;  // lui   (U)
      32'hFFFF_FFFC: return 32'h0080_006F;  // jal   (J)
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Memory model: one response per accepted request, resp_delay idle cycles after the accept cycle.
  initial begin : responder
    logic        fire, rst_s, pending;
    logic [31:0] faddr, paddr;
    int          cnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pending = 1'b0;
    paddr   = '0;
    cnt     = 0;
    forever begin
      @(negedge clk);
      fire  = imem_req_valid && imem_req_ready;
      faddr = imem_req_addr;
      rst_s = rst;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst_s) pending = 1'b0;
      else if (fire) begin
        pending = 1'b1;
        cnt     = resp_delay;
        paddr   = faddr;
      end
      if (pending) begin
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(paddr);
          pending         = 1'b0;
        end else cnt--;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    dec_ready       = 1'b1;
    imem_req_ready  = 1'b1;
    resp_delay      = 0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic               dr;
    logic               rdv;
    logic [31:0]        rdt;
    logic               rdy;
    logic               ev;
    logic [31:0]        epc;
    logic               erv;
    logic [31:0]        era;
    logic [6:0]         eop;
    logic [2:0]         ef3;
    instruction_op_type ety;
  } vec_t;

  function automatic vec_t mk(input logic dr, input logic rdv, input logic [31:0] rdt, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic erv, input logic [31:0] era,
                              input logic [6:0] eop, input logic [2:0] ef3, input instruction_op_type ety);
    vec_t v;
    v.dr = dr; v.rdv = rdv; v.rdt = rdt; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.erv = erv; v.era = era;
    v.eop = eop; v.ef3 = ef3; v.ety = ety;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vt[NV];

  initial begin : main
    //            dr    rdv   rdt            rdy   ev    epc    erv   era    op     f3    type
    vt[0]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[1]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[2]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,  1'b1, 32'h4,  7'h13, 3'd0, OP_TYPE_I);
    vt[3]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b0, 32'h0,  7'h33, 3'd0, OP_TYPE_R);
    vt[5]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b0, 32'h0,  7'h33, 3'd0, OP_TYPE_R);
    vt[6]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b0, 32'h0,  7'h33, 3'd0, OP_TYPE_R);
    vt[7]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b0, 32'h0,  7'h33, 3'd0, OP_TYPE_R);
    vt[8]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b0, 32'h0,  7'h33, 3'd0, OP_TYPE_R);
    vt[9]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,  1'b1, 32'h8,  7'h33, 3'd0, OP_TYPE_R);
    vt[10] = mk(1'b1, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[11] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 7'h00, 3'd0, OP_TYPE_X);
    vt[12] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[13] = mk(1'b1, 1'b1, 32'h80,       1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 7'h23, 3'd2, OP_TYPE_S);
    vt[14] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[15] = mk(1'b1, 1'b1, 32'hC0,       1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 7'h00, 3'd0, OP_TYPE_X);
    vt[16] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'hC0, 7'h00, 3'd0, OP_TYPE_X);
    vt[17] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  7'h00, 3'd0, OP_TYPE_X);
    vt[18] = mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC0, 1'b0, 32'h0,  7'h63, 3'd0, OP_TYPE_B);
    vt[19] = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC0, 1'b1, 32'hC4, 7'h63, 3'd0, OP_TYPE_B);

    // Reset state, sampled while rst is still high.
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst if_valid",   {31'b0, if_valid},         32'd0);
    chk("rst if_pc",      if_pc,                     32'h0);
    chk("rst if_instr",   if_instr,                  32'h0000_0013);
    chk("rst misaligned", {31'b0, fetch_misaligned}, 32'd0);
    chk("rst req_valid",  {31'b0, imem_req_valid},   32'd0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      dec_ready       = vt[i].dr;
      redirect_valid  = vt[i].rdv;
      redirect_target = vt[i].rdt;
      imem_req_ready  = vt[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d if_valid", i),  {31'b0, if_valid},       {31'b0, vt[i].ev});
      chk($sformatf("v%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].erv});
      if (vt[i].erv) chk($sformatf("v%0d req_addr", i), imem_req_addr, vt[i].era);
      if (vt[i].ev) begin
        chk($sformatf("v%0d if_pc", i),     if_pc,               vt[i].epc);
        chk($sformatf("v%0d if_instr", i),  if_instr,            mem_word(vt[i].epc));
        chk($sformatf("v%0d if_opcode", i), {25'b0, if_opcode},  {25'b0, vt[i].eop});
        chk($sformatf("v%0d if_funct3", i), {29'b0, if_funct3},  {29'b0, vt[i].ef3});
        chk($sformatf("v%0d if_optype", i), 32'(if_optype),      32'(vt[i].ety));
      end
      next_cycle();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;

    // Redirect while waiting on a slow response for addr 8: the late response must be dropped.
    do_reset();
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    resp_delay = 2;
    @(negedge clk);
    chk("kill req_addr8", imem_req_addr, 32'h8);
    chk("kill req_valid8", {31'b0, imem_req_valid}, 32'd1);
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    @(negedge clk);
    chk("kill wait rv", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("kill wait2 rv", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    resp_delay = 0;
    @(negedge clk);
    chk("kill resp if_valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("kill drop if_valid", {31'b0, if_valid}, 32'd0);
    chk("kill req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("kill req_addr", imem_req_addr, 32'h100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("kill if_valid", {31'b0, if_valid}, 32'd1);
    chk("kill if_pc", if_pc, 32'h100);
    chk("kill if_instr", if_instr, 32'h0000_10B7);
    chk("kill if_optype", 32'(if_optype), 32'(OP_TYPE_U));

    // Misaligned redirect with a request accepted the same cycle: halt, then reset recovers.
    do_reset();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'h102;
    @(negedge clk);
    chk("mis pre if_valid", {31'b0, if_valid}, 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis flag", {31'b0, fetch_misaligned}, 32'd1);
    chk("mis if_valid", {31'b0, if_valid}, 32'd0);
    chk("mis req_valid", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'h200;
    @(negedge clk);
    chk("halt req_valid", {31'b0, imem_req_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d req_valid", k), {31'b0, imem_req_valid}, 32'd0);
      chk($sformatf("halt%0d if_valid", k), {31'b0, if_valid}, 32'd0);
      chk($sformatf("halt%0d flag", k), {31'b0, fetch_misaligned}, 32'd1);
      next_cycle();
    end
    do_reset();
    @(negedge clk);
    chk("mis rst flag", {31'b0, fetch_misaligned}, 32'd0);
    chk("mis rst req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("mis rst req_addr", imem_req_addr, 32'h0);

    // PC wrap: stall the request, redirect to the last word, fetch it, expect next addr 0.
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    next_cycle();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap req_addr", imem_req_addr, 32'hFFFF_FFFC);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("wrap if_valid", {31'b0, if_valid}, 32'd1);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap if_opcode", {25'b0, if_opcode}, 32'h6F);
    chk("wrap if_optype", 32'(if_optype), 32'(OP_TYPE_J));
    chk("wrap next addr", imem_req_addr, 32'h0);
    chk("wrap next rv", {31'b0, imem_req_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the decode/control stage. Holds the PC and issues one instruction-memory read at a time.
- Buffers the returned word in a one-entry output register, then presents the pc, the instruction, and the pre-extracted opcode, funct3 and optype to decode.
- Accepts a redirect (branch taken or jump) from the control stage, flushes wrong-path work, and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits[1:0] must be 0.
- XLEN, 32: address and instruction width. Only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word-aligned read address.
- imem_resp_valid  in  1  read data valid; exactly one response per accepted request, in order.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse: branch taken or jump.
- redirect_target  in  32  new PC.
- dec_ready  in  1  decode consumes the output this cycle.
- if_valid  out  1  output buffer holds a valid instruction.
- if_pc  out  32  PC of the buffered instruction.
- if_instr  out  32  buffered instruction word.
- if_opcode  out  7  if_instr[6:0].
- if_funct3  out  3  if_instr[14:12].
- if_optype  out  instruction_op_type  decoded from if_opcode.
- fetch_misaligned  out  1  sticky error flag.

Behaviour:
- Reset, applied on the clk edge while rst=1:
  - pc_q=RESET_PC; state=S_REQ; kill=0.
  - if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), fetch_misaligned=0, imem_req_valid=0.
  - rst asserted mid-transaction abandons the outstanding request. After rst, the first imem_resp_valid is ignored only if kill was set; the memory side must also be reset.
- S_REQ:
  - imem_req_valid = !if_valid || dec_ready; imem_req_addr = pc_q.
  - On valid && ready: go to S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with kill=0: if_instr <= data, if_pc <= pc_q, if_valid <= 1, pc_q <= pc_q+4, go to S_REQ.
  - On imem_resp_valid with kill=1: discard the data, clear kill, go to S_REQ.
- S_HALT: no requests; if_valid=0. Exit only by rst.
- Output handshake:
  - if_valid && dec_ready consumes the entry; if_valid clears unless a response loads the buffer in the same cycle.
  - Output registers are stable while if_valid && !dec_ready.
  - Only one outstanding request at a time. A request is issued only when the buffer is empty or draining, so a response always finds a free buffer.
- Latency: request-to-if_valid is 1 cycle after imem_resp_valid. Steady state with zero-wait memory is one instruction per 2 cycles.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect (redirect_valid=1), taking priority over every other event in that cycle:
  - pc_q <= redirect_target; if_valid <= 0, even if dec_ready=1.
  - In S_WAIT without a response this cycle: kill <= 1.
  - In S_WAIT with a response this cycle: the response is discarded; go to S_REQ.
  - In S_REQ with the request accepted this cycle: go to S_WAIT with kill <= 1.
  - In S_REQ with no request accepted: stay in S_REQ at the new pc.
  - redirect_target[1:0] != 0: fetch_misaligned <= 1, go to S_HALT, and any in-flight response is dropped.
- redirect_valid during S_HALT is ignored.

Decomposition:
- Package common gains:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HALT}.
  - constant NOP_INSTR = 32'h0000_0013.
  - constant PC_STEP = 4.
- Reuse the existing instruction_op_type and opcode constants from common.
- One sub-module, optype_decoder: combinational, 7-bit opcode in, instruction_op_type out (R/I/S/B/U/J). Shared later by decode.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory returning 32'h00500093 at address 0:
  - first request addr=0 one cycle after rst drops;
  - if_valid=1, if_pc=0, if_opcode=7'h13, if_funct3=0.
  - Next request addr=4.
- dec_ready=0 for 5 cycles with the buffer full: no new imem_req_valid; if_pc and if_instr stable. dec_ready=1 then yields a request to the next pc.
- Redirect to 32'h0000_0100 while in S_WAIT for addr 8, response arriving 2 cycles later:
  - that response is dropped (if_valid stays 0);
  - the next request addr=0x100, and the next if_pc=0x100.
- Redirect in the same cycle as imem_resp_valid: data discarded; if_valid=0 next cycle; next request addr=target.
- redirect_target=32'h0000_0102: fetch_misaligned=1 next cycle, no further imem_req_valid, if_valid=0; rst clears the flag and restarts at RESET_PC.
- pc_q=32'hFFFF_FFFC, response returned: if_pc=32'hFFFF_FFFC; next request addr=32'h0000_0000.
